cpu_ctrl: RTL and testbench
===========================

// Module: cpu_ctrl
// PURPOSE
//   Multi-cycle fetch/execute controller for the 8-bit RISC-like CPU; it sources opcode and operands for the alu block.
//   Fetches 16-bit instructions over a req/ack imem port and holds a 4x8 register file, PC and Z flag.
//   Drives alu_op/alu_in0/alu_in1 and consumes alu_out/alu_zf for writeback, memory addressing and branches.
//   Issues LOAD/STORE over a req/ack dmem port.
// PARAMETERS
//   RESET_PC   8'h00   PC value loaded on reset
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   synchronous reset, active-high
//   imem_req    out  1   instruction fetch request
//   imem_addr   out  8   fetch address (= PC)
//   imem_ack    in   1   fetch done; imem_data valid this cycle
//   imem_data   in   16  instruction {op[15:12], rd[11:10], rs[9:8], imm[7:0]}
//   dmem_req    out  1   data access request
//   dmem_we     out  1   1 = STORE, 0 = LOAD
//   dmem_addr   out  8   data address
//   dmem_wdata  out  8   store data (= R[rd])
//   dmem_ack    in   1   access done; dmem_rdata valid this cycle for LOAD
//   dmem_rdata  in   8   load data
//   alu_op      out  4   = IR[15:12] (combinational)
//   alu_in0     out  8   operand 0 (see table)
//   alu_in1     out  8   operand 1 (see table)
//   alu_out     in   8   ALU result
//   alu_zf      in   1   1 when alu_out == 0
//   halted      out  1   1 after HALT executed
// BEHAVIOUR
// - Opcodes: AND=0, OR=1, ADD=2, SUB=3, CMP=4, ADDI=5, SUBI=6, CMPI=7.
// - Opcodes (cont.): LOAD=8, STORE=9, JMP=10, JMPR=11, JNZ=12, LI=13, NOP=14, HALT=15.
// - Operands:
//   - AND/OR/ADD/SUB/CMP: in0=R[rs], in1=R[rd].
//   - ADDI/SUBI/CMPI: in0=imm, in1=R[rd].
//   - LOAD/STORE/JMPR: in0=imm, in1=R[rs].
//   - JMP/JNZ/LI: in0=imm, in1=0.
//   - NOP/HALT: in0=in1=0.
//   - SUB computes rd-rs on the ALU side.
// - FSM states: FETCH, EXEC, MEM, HALT.
//   - FETCH: imem_req=1, imem_addr=PC held stable until imem_ack. On ack: IR<=imem_data, go to EXEC.
//   - EXEC (1 cycle):
//     - AND/OR/ADD/SUB/ADDI/SUBI/LI: R[rd]<=alu_out.
//     - AND/OR/ADD/SUB/ADDI/SUBI/CMP/CMPI: Z<=alu_zf. CMP/CMPI write no register.
//     - LOAD/STORE: MAR<=alu_out, go to MEM.
//     - JMP/JMPR: PC<=alu_out.
//     - JNZ: PC<=alu_out if Z==0, else PC+1.
//     - HALT: go to HALT.
//     - All other opcodes: PC<=PC+1, then FETCH.
//   - MEM: dmem_req=1; dmem_addr/we/wdata held until dmem_ack.
//     - On ack, LOAD writes R[rd]<=dmem_rdata.
//     - Then PC<=PC+1, go to FETCH.
//   - HALT: all req low; exits only on rst.
// - Latency (zero-wait ack): ALU/jump instruction 2 cycles; LOAD/STORE 3 cycles.
// - PC arithmetic is 8-bit modulo; 8'hFF+1 -> 8'h00.
// - Z flag: CMP gives out=1 on equal, so Z=0 and JNZ is taken after an equal compare.
// - An ack seen outside the matching state is ignored.
// - Reset (overrides everything, including a mid-transaction request):
//   - Next cycle: PC=RESET_PC, IR=16'h0000, R0..R3=0, Z=1, state=FETCH.
//   - imem_req=0 and dmem_req=0 while rst is high; halted=0.
//   - An ack in a reset cycle is dropped.
//   - First imem_req rises in the first cycle after rst falls.
// TESTING
// - Reset: hold rst 2 cycles mid-MEM -> dmem_req drops; after release imem_req=1, imem_addr=8'h00, halted=0.
// - Write: LI r1,5; LI r2,3; SUB r1,r2 -> at SUB EXEC alu_op=3, in0=3, in1=5; R1 becomes 2.
// - Readback: STORE r1 then check -> dmem_wdata=2.
// - Store timing: STORE r1,[r2+0x10], dmem_ack delayed 3 cycles -> dmem_req/addr=8'h13/we=1/wdata=2 stable 4 cycles; next fetch addr+1.
// - Branch: CMPI r1,2 then JNZ 0x40 -> next imem_addr=8'h40. CMPI r1,7 then JNZ 0x40 -> fall through to PC+1.
// - PC wrap: JMP 0xFF; NOP at 0xFF -> fetch after NOP at 8'h00.
// - Halt: HALT -> halted=1, no req for 10 cycles even with imem_ack pulsed; rst -> halted=0, fetch resumes at 8'h00.

Source files
------------

// File: rtl/cpu_ctrl_if.sv
// Bus bundle between the fetch/execute controller and its neighbours:
// instruction memory, data memory and the external ALU.
interface cpu_ctrl_if;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;

  logic        dmem_req;
  logic        dmem_we;
  logic [7:0]  dmem_addr;
  logic [7:0]  dmem_wdata;
  logic        dmem_ack;
  logic [7:0]  dmem_rdata;

  logic [3:0]  alu_op;
  logic [7:0]  alu_in0;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_out;
  logic        alu_zf;

  // Controller side
  modport master (
    output imem_req, imem_addr, input imem_ack, imem_data,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata,
    output alu_op, alu_in0, alu_in1, input alu_out, alu_zf
  );

  // Memory / ALU side
  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_data,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata,
    input alu_op, alu_in0, alu_in1, output alu_out, alu_zf
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/execute controller for the 8-bit CPU. Holds PC, IR,
// a 4x8 register file and the Z flag; the arithmetic itself lives in the
// external ALU, which this block feeds with opcode and operands.
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  cpu_ctrl_if.master bus,
  output logic       halted
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SUBI = 4'd6;
  localparam logic [3:0] OP_CMPI = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_STOR = 4'd9;
  localparam logic [3:0] OP_JMP  = 4'd10;
  localparam logic [3:0] OP_JMPR = 4'd11;
  localparam logic [3:0] OP_JNZ  = 4'd12;
  localparam logic [3:0] OP_LI   = 4'd13;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t      state_reg;
  logic [7:0]  pc_reg;
  logic [7:0]  mar_reg;
  logic [15:0] ir_reg;
  logic [7:0]  rf_reg [4];
  logic        z_reg;

  logic [3:0]  op;
  logic [1:0]  rd;
  logic [1:0]  rs;
  logic [7:0]  imm;
  logic [7:0]  pc_next;

  assign op      = ir_reg[15:12];
  assign rd      = ir_reg[11:10];
  assign rs      = ir_reg[9:8];
  assign imm     = ir_reg[7:0];
  assign pc_next = pc_reg + 8'd1;

  // Requests are gated by rst so they drop in the very first reset cycle.
  assign bus.imem_req   = (state_reg == S_FETCH) && !rst;
  assign bus.imem_addr  = pc_reg;
  assign bus.dmem_req   = (state_reg == S_MEM) && !rst;
  assign bus.dmem_we    = (op == OP_STOR);
  assign bus.dmem_addr  = mar_reg;
  assign bus.dmem_wdata = rf_reg[rd];
  assign bus.alu_op     = op;
  assign halted         = (state_reg == S_HALT) && !rst;

  // Operand selection for the ALU, decoded from the held instruction.
  always_comb begin
    bus.alu_in0 = 8'h00;
    bus.alu_in1 = 8'h00;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_CMP: begin
        bus.alu_in0 = rf_reg[rs];
        bus.alu_in1 = rf_reg[rd];
      end
      OP_ADDI, OP_SUBI, OP_CMPI: begin
        bus.alu_in0 = imm;
        bus.alu_in1 = rf_reg[rd];
      end
      OP_LOAD, OP_STOR, OP_JMPR: begin
        bus.alu_in0 = imm;
        bus.alu_in1 = rf_reg[rs];
      end
      OP_JMP, OP_JNZ, OP_LI: begin
        bus.alu_in0 = imm;
      end
      default: ;
    endcase
  end

  // Controller FSM together with all architectural state updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      mar_reg   <= 8'h00;
      ir_reg    <= 16'h0000;
      z_reg     <= 1'b1;
      for (int i = 0; i < 4; i++) rf_reg[i] <= 8'h00;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir_reg    <= bus.imem_data;
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_reg <= S_FETCH;
          case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
              rf_reg[rd] <= bus.alu_out;
              z_reg      <= bus.alu_zf;
              pc_reg     <= pc_next;
            end
            OP_CMP, OP_CMPI: begin
              z_reg  <= bus.alu_zf;
              pc_reg <= pc_next;
            end
            OP_LI: begin
              rf_reg[rd] <= bus.alu_out;
              pc_reg     <= pc_next;
            end
            OP_LOAD, OP_STOR: begin
              mar_reg   <= bus.alu_out;
              state_reg <= S_MEM;
            end
            OP_JMP, OP_JMPR: pc_reg <= bus.alu_out;
            OP_JNZ:          pc_reg <= z_reg ? pc_next : bus.alu_out;
            OP_HALT:         state_reg <= S_HALT;
            default:         pc_reg <= pc_next;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ack) begin
            if (op == OP_LOAD) rf_reg[rd] <= bus.dmem_rdata;
            pc_reg    <= pc_next;
            state_reg <= S_FETCH;
          end
        end
        default: ;  // S_HALT: wait for reset
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Bench for cpu_ctrl: directed scenarios plus a random instruction stream,
// checked against an instruction-level model of the architecture.
module tb_cpu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halted;

  always #5 clk = ~clk;

  cpu_ctrl_if bus();

  cpu_ctrl #(.RESET_PC(8'h00)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .halted (halted)
  );

  // Behavioural ALU the controller is paired with. CMP-type ops return 1 on equal.
  always_comb begin
    case (bus.alu_op)
      4'd0:       bus.alu_out = bus.alu_in0 & bus.alu_in1;
      4'd1:       bus.alu_out = bus.alu_in0 | bus.alu_in1;
      4'd3, 4'd6: bus.alu_out = bus.alu_in1 - bus.alu_in0;
      4'd4, 4'd7: bus.alu_out = (bus.alu_in0 == bus.alu_in1) ? 8'd1 : 8'd0;
      default:    bus.alu_out = bus.alu_in0 + bus.alu_in1;
    endcase
    bus.alu_zf = (bus.alu_out == 8'd0);
  end

  int checks   = 0;
  int failures = 0;

  // Architectural model
  logic [7:0] m_r [4];
  logic       m_z;
  logic [7:0] m_pc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int rd, input int rs, input int imm);
    ins = {4'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_z  = 1'b1;
    m_pc = 8'h00;
  endfunction

  // Called at a falling edge; holds rst for n rising edges.
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("rst_imem_req", 32'(bus.imem_req), 0);
      check("rst_dmem_req", 32'(bus.dmem_req), 0);
      bus.imem_ack = 1'($urandom_range(0, 1));
      bus.dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rst = 1'b0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    model_reset();
    #1;
    check("post_rst_imem_req", 32'(bus.imem_req), 1);
    check("post_rst_imem_addr", 32'(bus.imem_addr), 32'h00);
    check("post_rst_halted", 32'(halted), 0);
  endtask

  // Deliver one instruction after wt wait cycles; returns at the EXEC falling edge.
  task automatic fetch(input logic [15:0] word, input int wt);
    int n = 0;
    while (!bus.imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("imem_req_seen", 32'(bus.imem_req), 1);
    check("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
    for (int i = 0; i < wt; i++) begin
      bus.dmem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("fetch_hold", {23'd0, bus.imem_req, bus.imem_addr}, {23'd0, 1'b1, m_pc});
    end
    bus.dmem_ack  = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'($urandom);
  endtask

  // Check EXEC operands, advance the model, service any data access.
  task automatic exec_ins(input logic [15:0] word, input int dwt, input logic [7:0] rdata,
                          input bit hold_mem);
    logic [3:0] op;
    logic [1:0] rd, rs;
    logic [7:0] imm, e0, e1, ea, ew, pc_inc;
    op = word[15:12]; rd = word[11:10]; rs = word[9:8]; imm = word[7:0];
    e0 = 8'h00; e1 = 8'h00;
    if (op <= 4'd4)                           begin e0 = m_r[rs]; e1 = m_r[rd]; end
    else if (op <= 4'd7)                      begin e0 = imm;     e1 = m_r[rd]; end
    else if (op == 8 || op == 9 || op == 11)  begin e0 = imm;     e1 = m_r[rs]; end
    else if (op == 10 || op == 12 || op == 13) e0 = imm;
    check("alu_op", 32'(bus.alu_op), 32'(op));
    check("alu_in0", 32'(bus.alu_in0), 32'(e0));
    check("alu_in1", 32'(bus.alu_in1), 32'(e1));

    ea = imm + m_r[rs];
    ew = m_r[rd];
    pc_inc = m_pc + 8'd1;
    case (op)
      4'd0:  begin m_r[rd] = m_r[rd] & m_r[rs]; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd1:  begin m_r[rd] = m_r[rd] | m_r[rs]; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd2:  begin m_r[rd] = m_r[rd] + m_r[rs]; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd3:  begin m_r[rd] = m_r[rd] - m_r[rs]; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd4:  begin m_z = (m_r[rs] != m_r[rd]); m_pc = pc_inc; end
      4'd5:  begin m_r[rd] = m_r[rd] + imm; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd6:  begin m_r[rd] = m_r[rd] - imm; m_z = (m_r[rd] == 0); m_pc = pc_inc; end
      4'd7:  begin m_z = (imm != m_r[rd]); m_pc = pc_inc; end
      4'd8:  begin m_r[rd] = rdata; m_pc = pc_inc; end
      4'd9:  m_pc = pc_inc;
      4'd10: m_pc = imm;
      4'd11: m_pc = ea;
      4'd12: m_pc = m_z ? pc_inc : imm;
      4'd13: begin m_r[rd] = imm; m_pc = pc_inc; end
      4'd14: m_pc = pc_inc;
      default: ;
    endcase

    // A data ack during EXEC must be ignored.
    bus.dmem_ack = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.dmem_ack = 1'b0;

    if (op == 4'd8 || op == 4'd9) begin
      for (int i = 0; i <= dwt; i++) begin
        check("dmem_req", 32'(bus.dmem_req), 1);
        check("dmem_we", 32'(bus.dmem_we), 32'(op == 4'd9));
        check("dmem_addr", 32'(bus.dmem_addr), 32'(ea));
        if (op == 4'd9) check("dmem_wdata", 32'(bus.dmem_wdata), 32'(ew));
        if (hold_mem) return;
        if (i < dwt) begin
          bus.imem_ack = 1'($urandom_range(0, 1));
          @(negedge clk);
        end else begin
          bus.imem_ack   = 1'b0;
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
          @(negedge clk);
          bus.dmem_ack   = 1'b0;
        end
      end
    end

    if (op == 4'd15) begin
      check("halted", 32'(halted), 1);
      check("halt_imem_req", 32'(bus.imem_req), 0);
    end else begin
      check("next_fetch_latency", 32'(bus.imem_req), 1);
    end
  endtask

  task automatic run(input logic [15:0] word, input int iwt, input int dwt, input logic [7:0] rdata);
    logic [7:0] pc0;
    pc0 = m_pc;
    fetch(word, iwt);
    exec_ins(word, dwt, rdata, 1'b0);
    $display("txn pc=%02h ins=%04h next_pc=%02h", pc0, word, m_pc);
  endtask

  initial begin
    bus.imem_ack   = 1'b0;
    bus.imem_data  = 16'h0000;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset(2);

    // Write path: SUB computes rd - rs
    run(ins(13, 1, 0, 5), 0, 0, 0);
    run(ins(13, 2, 0, 3), 1, 0, 0);
    fetch(ins(3, 1, 2, 0), 0);
    check("sub_alu_op", 32'(bus.alu_op), 3);
    check("sub_in0", 32'(bus.alu_in0), 3);
    check("sub_in1", 32'(bus.alu_in1), 5);
    exec_ins(ins(3, 1, 2, 0), 0, 0, 1'b0);

    // STORE r1,[r2+0x10] with a 3-cycle delayed ack
    fetch(ins(9, 1, 2, 8'h10), 0);
    exec_ins(ins(9, 1, 2, 8'h10), 3, 0, 1'b0);
    check("store_next_fetch", 32'(bus.imem_addr), 32'h04);

    // Branches after equal and unequal compare
    run(ins(7, 1, 0, 2), 0, 0, 0);
    run(ins(12, 0, 0, 8'h40), 0, 0, 0);
    check("jnz_taken", 32'(bus.imem_addr), 32'h40);
    run(ins(7, 1, 0, 7), 0, 0, 0);
    run(ins(12, 0, 0, 8'h40), 0, 0, 0);
    check("jnz_fallthrough", 32'(bus.imem_addr), 32'h42);

    // PC wrap
    run(ins(10, 0, 0, 8'hFF), 0, 0, 0);
    run(ins(14, 0, 0, 0), 2, 0, 0);
    check("pc_wrap", 32'(bus.imem_addr), 32'h00);

    // Reset while a LOAD is waiting in MEM
    fetch(ins(8, 3, 1, 8'h20), 0);
    exec_ins(ins(8, 3, 1, 8'h20), 0, 8'h55, 1'b1);
    do_reset(2);
    // Z resets to 1, so JNZ falls through
    run(ins(12, 0, 0, 8'h80), 0, 0, 0);
    check("jnz_after_reset", 32'(bus.imem_addr), 32'h01);

    // Random instruction stream (HALT excluded)
    for (int k = 0; k < 300; k++) begin
      run(ins($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)),
          $urandom_range(0, 2), $urandom_range(0, 2), 8'($urandom));
    end

    // HALT: no requests, stray acks ignored, reset revives
    run(ins(15, 0, 0, 0), 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      bus.imem_ack = 1'(i % 2);
      bus.dmem_ack = 1'((i + 1) % 2);
      @(negedge clk);
      check("halt_hold", {29'd0, halted, bus.imem_req, bus.dmem_req}, 32'b100);
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    do_reset(1);
    run(ins(13, 0, 0, 8'hA5), 0, 0, 0);
    run(ins(9, 0, 0, 8'h01), 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
